div_seq: RTL and testbench
==========================

# div_seq

Sequential signed divider for the multi-cycle MIPS datapath. It answers the control unit's divide request: on a `DivCtrl` start pulse it samples registers A and B and runs a radix-2 restoring division over 32 iterations. It then presents the remainder to the HI write mux and the quotient to the LO write mux, with a one-cycle `done` pulse. The control unit holds in its DIV wait state until `done` (or `div_zero`), then asserts `HiCtrl`/`LoCtrl`.

## Interface

- `WIDTH`, default 32: operand and result width. Iteration counter is `$clog2(WIDTH)+1` bits.

- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `div_start`  in  1  start request (driven by `DivCtrl`); sampled only in IDLE.
- `dividend`  in  WIDTH  signed dividend (register A output); sampled at the accepting edge.
- `divisor`  in  WIDTH  signed divisor (register B output); sampled at the accepting edge.
- `hi`  out  WIDTH  remainder, registered.
- `lo`  out  WIDTH  quotient, registered.
- `busy`  out  1  high from the accepting edge until the completing edge.
- `done`  out  1  one-cycle completion pulse.
- `div_zero`  out  1  one-cycle pulse: divide-by-zero detected (see Configuration).

## Operation

- States: IDLE, CALC, FIX.
- IDLE with `div_start`=1 (accepting edge):
  - Latch |dividend| into the quotient shift register Q.
  - Latch |divisor| into M.
  - Clear partial remainder R (WIDTH+1 bits).
  - Store `sign_q` = dividend[MSB] ^ divisor[MSB] and `sign_r` = dividend[MSB].
  - Count = 0; go to CALC.
- Absolute values are taken as unsigned WIDTH-bit magnitudes, so 0x80000000 maps to magnitude 0x80000000.
- CALC, per edge:
  - {R,Q} shifts left 1. Trial T = R_shifted − {1'b0,M}.
  - If T ≥ 0: R = T, Q[0] = 1. Otherwise R keeps the shifted value and Q[0] = 0.
  - Count increments. After WIDTH iterations go to FIX.
- FIX (one edge):
  - `lo` = `sign_q` ? −Q : Q.
  - `hi` = `sign_r` ? −R[WIDTH-1:0] : R[WIDTH-1:0].
  - `done` = 1; go to IDLE.
- Semantics are MIPS `div`: quotient truncates toward zero, remainder takes the dividend's sign. INT_MIN / −1 yields `lo`=0x80000000, `hi`=0, with no overflow flag.
- `div_start` in CALC or FIX is ignored. Operand changes after the accepting edge have no effect.
- `hi`/`lo` hold their last values until the next completion. They are never updated mid-operation.

## Timing

- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0, state IDLE, count 0.
- Accepting edge k. CALC covers edges k+1..k+32; FIX is edge k+33.
- `done` is high for exactly the cycle after edge k+33: 33-cycle latency. `busy` is high for cycles following edges k..k+32.
- The control unit samples `hi`/`lo` while `done`=1. The values stay valid afterwards.
- Back-to-back: `div_start` high during the `done` cycle is accepted, because state is already IDLE.
- Reset asserted mid-operation aborts immediately with all outputs at reset values. The first accept is allowed on the first edge after deassertion.

## Configuration

- `DIV_ZERO_CHECK_EN` defined:
  - At the accepting edge, if `divisor`==0, do not enter CALC. Pulse `div_zero`=1 and `done`=1 in the next cycle (latency 1) and stay in IDLE.
  - `hi`/`lo` are unchanged. The control unit routes this to the divide-by-zero exception.
- `DIV_ZERO_CHECK_EN` not defined:
  - `div_zero` is tied 0. A zero divisor runs the normal 33-cycle sequence.
  - Result: Q=all ones, R=|dividend|, then sign-corrected. Example: 5/0 gives `lo`=0xFFFFFFFF, `hi`=5; −5/0 gives `lo`=1, `hi`=0xFFFFFFFB.

## Test plan

- 7 / 2, pulse `div_start` at edge k -> `done` after edge k+33; `lo`=3, `hi`=1; `busy` high for exactly 33 cycles.
- −7 / 2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Then 7 / −2 -> `lo`=0xFFFFFFFD, `hi`=1.
- 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0. Then 0x12345678 / 0x12345678 -> `lo`=1, `hi`=0.
- 100 / 0:
  - with `DIV_ZERO_CHECK_EN` -> `div_zero`=`done`=1 one cycle after accept; `hi`/`lo` keep prior values.
  - without it -> `done` at 33 cycles; `lo`=0xFFFFFFFF, `hi`=100.
- 50 / 7, then `div_start` re-pulsed with 9 / 3 at edge k+10 -> ignored; result `lo`=7, `hi`=1. A pulse of 9 / 3 during the `done` cycle -> accepted; result `lo`=3, `hi`=0 thirty-three cycles later.
- `reset` low at edge k+15 of 1000 / 3 -> all outputs 0 asynchronously, no `done` pulse. After release, 1000 / 3 -> `lo`=333, `hi`=1.

Source files
------------

// File: rtl/div_seq_if.sv
// Handshake and operand bundle between the MIPS control unit / register file and div_seq.
// The control side uses the master modport and the divider uses the slave modport.
interface div_seq_if #(
    parameter int WIDTH = 32
);
    logic             div_start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output div_start, dividend, divisor,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  div_start, dividend, divisor,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/div_seq.sv
// Sequential signed divider (MIPS div): 32-step radix-2 restoring loop, remainder on hi, quotient on lo.
// Optional feature macro DIV_ZERO_CHECK_EN: trap a zero divisor at accept with a one-cycle div_zero/done pulse.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic      clock,
    input  logic      reset,
    div_seq_if.slave  div_bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH:0]   r_q;
    logic             sign_quo_q;
    logic             sign_rem_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;
    logic             div_zero_q;

    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;
    logic             trial_ok;
    logic [WIDTH:0]   r_d;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] rem_mag;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;
    logic             zero_trap;
    logic             r_top_unused;

    // Magnitudes are plain unsigned WIDTH-bit values, so the most negative input maps onto itself.
    assign dividend_mag = div_bus.dividend[WIDTH-1] ? -div_bus.dividend : div_bus.dividend;
    assign divisor_mag  = div_bus.divisor[WIDTH-1]  ? -div_bus.divisor  : div_bus.divisor;

    assign r_shift  = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign trial    = r_shift - {1'b0, m_q};
    assign trial_ok = (r_shift >= {1'b0, m_q});
    assign r_d      = trial_ok ? trial : r_shift;
    assign q_d      = {q_q[WIDTH-2:0], trial_ok};

    // The remainder always ends below 2**WIDTH, so only the low WIDTH bits reach hi.
    assign rem_mag      = r_q[WIDTH-1:0];
    assign r_top_unused = r_q[WIDTH];
    assign hi_d         = sign_rem_q ? -rem_mag : rem_mag;
    assign lo_d         = sign_quo_q ? -q_q : q_q;

`ifdef DIV_ZERO_CHECK_EN
    assign zero_trap = div_bus.div_start && (div_bus.divisor == '0);
`else
    assign zero_trap = 1'b0;
`endif

    // NOTE: every register here, the datapath included, is cleared by reset, so the asynchronous abort leaves no stale operand behind.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            q_q        <= '0;
            m_q        <= '0;
            r_q        <= '0;
            sign_quo_q <= 1'b0;
            sign_rem_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so each register samples the pre-edge state of every other.
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (zero_trap) begin
                        done_q     <= 1'b1;
                        div_zero_q <= 1'b1;
                    end else if (div_bus.div_start) begin
                        q_q        <= dividend_mag;
                        m_q        <= divisor_mag;
                        r_q        <= '0;
                        sign_quo_q <= div_bus.dividend[WIDTH-1] ^ div_bus.divisor[WIDTH-1];
                        sign_rem_q <= div_bus.dividend[WIDTH-1];
                        count_q    <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_q     <= r_d;
                    q_q     <= q_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == CW'(WIDTH - 1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign div_bus.hi       = hi_q;
    assign div_bus.lo       = lo_q;
    assign div_bus.busy     = busy_q;
    assign div_bus.done     = done_q;
    assign div_bus.div_zero = div_zero_q;
endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: signed cases, INT_MIN/-1, zero divisor, ignored restart,
// back-to-back accept in the done cycle and mid-operation reset.
module tb_div_seq;
    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   lat;
    int   busy_cnt;
    int   done_seen;

    div_seq_if #(.WIDTH(32)) bus ();

    div_seq #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset   (reset),
        .div_bus (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the following posedge is the accepting edge k. Returns at the negedge after k.
    task automatic accept(input logic [31:0] a, input logic [31:0] b);
        bus.div_start = 1'b1;
        bus.dividend  = a;
        bus.divisor   = b;
        @(negedge clock);
        bus.div_start = 1'b0;
        bus.dividend  = $urandom;
        bus.divisor   = $urandom;
    endtask

    // Samples at negedges; lat is the number of edges after the accepting edge when done is seen.
    task automatic wait_done(input int j0, output int lat_o, output int busy_o);
        lat_o  = j0;
        busy_o = 0;
        while (bus.done !== 1'b1 && lat_o < 100) begin
            if (bus.busy === 1'b1) busy_o++;
            @(negedge clock);
            lat_o++;
        end
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] lo_exp, input logic [31:0] hi_exp);
        int l;
        int bc;
        accept(a, b);
        wait_done(0, l, bc);
        check({tag, "_latency"}, l, 33);
        check({tag, "_lo"}, bus.lo, lo_exp);
        check({tag, "_hi"}, bus.hi, hi_exp);
    endtask

    initial begin
        reset         = 1'b0;
        bus.div_start = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(negedge clock);
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_div_zero", bus.div_zero, 0);
        reset = 1'b1;

        // 7 / 2, accepted on the first edge after reset release
        accept(32'd7, 32'd2);
        wait_done(0, lat, busy_cnt);
        check("p7_2_latency", lat, 33);
        check("p7_2_busy_cycles", busy_cnt, 33);
        check("p7_2_lo", bus.lo, 32'd3);
        check("p7_2_hi", bus.hi, 32'd1);
        check("p7_2_div_zero", bus.div_zero, 0);
        @(negedge clock);
        check("p7_2_done_one_cycle", bus.done, 0);
        check("p7_2_busy_after", bus.busy, 0);
        check("p7_2_lo_hold", bus.lo, 32'd3);
        check("p7_2_hi_hold", bus.hi, 32'd1);

        run("m7_2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run("p7_m2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        run("intmin_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run("same", 32'h1234_5678, 32'h1234_5678, 32'd1, 32'd0);

        // 100 / 0
`ifdef DIV_ZERO_CHECK_EN
        accept(32'd100, 32'd0);
        check("dz_done", bus.done, 1);
        check("dz_flag", bus.div_zero, 1);
        check("dz_busy", bus.busy, 0);
        check("dz_lo_kept", bus.lo, 32'd1);
        check("dz_hi_kept", bus.hi, 32'd0);
        @(negedge clock);
        check("dz_done_one_cycle", bus.done, 0);
        check("dz_flag_one_cycle", bus.div_zero, 0);
`else
        accept(32'd100, 32'd0);
        wait_done(0, lat, busy_cnt);
        check("dz_latency", lat, 33);
        check("dz_lo", bus.lo, 32'hFFFF_FFFF);
        check("dz_hi", bus.hi, 32'd100);
        check("dz_flag_tied", bus.div_zero, 0);
        @(negedge clock);
`endif

        // 50 / 7 with an ignored restart at edge k+10
        accept(32'd50, 32'd7);
        repeat (9) @(negedge clock);
        bus.div_start = 1'b1;
        bus.dividend  = 32'd9;
        bus.divisor   = 32'd3;
        @(negedge clock);
        bus.div_start = 1'b0;
        check("restart_busy", bus.busy, 1);
        wait_done(10, lat, busy_cnt);
        check("restart_latency", lat, 33);
        check("restart_lo", bus.lo, 32'd7);
        check("restart_hi", bus.hi, 32'd1);

        // 9 / 3 requested during the done cycle is accepted
        accept(32'd9, 32'd3);
        check("b2b_busy", bus.busy, 1);
        wait_done(0, lat, busy_cnt);
        check("b2b_latency", lat, 33);
        check("b2b_lo", bus.lo, 32'd3);
        check("b2b_hi", bus.hi, 32'd0);

        // reset at edge k+15 of 1000 / 3
        @(negedge clock);
        accept(32'd1000, 32'd3);
        repeat (14) @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        #1;
        check("abort_hi", bus.hi, 0);
        check("abort_lo", bus.lo, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.done === 1'b1) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        reset = 1'b1;
        run("after_rst", 32'd1000, 32'd3, 32'd333, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
